// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and group propagate/generate type for the pipelined CLA adder
package cla_pkg;
  localparam int CLA_GROUP_W = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_STAGES  = 4;
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;
endpackage

// File: rtl/cla_group.sv
// cla_group: 4-bit carry-lookahead group with group propagate/generate outputs
module cla_group
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   c_in,
  output logic [CLA_GROUP_W-1:0] sum,
  output pg_t                    pg
);
  logic [3:0] p, g, c;
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    sum = p ^ c;
    pg.p = &p;
    pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: STAGES-deep pipelined carry-lookahead adder/subtractor with valid/ready flow control
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / CLA_GROUP_W;
  localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;

  if (WIDTH % CLA_GROUP_W != 0 || WIDTH < 8 || STAGES < 1 || (WIDTH / CLA_GROUP_W) % STAGES != 0) begin : g_bad_params
    $error("pipe_cla_adder: illegal WIDTH/STAGES combination");
  end

  logic                        adv;
  logic [STAGES-1:0]           v_d, v_q;
  logic [WIDTH-1:0]            ai [STAGES];
  logic [WIDTH-1:0]            bi [STAGES];
  logic [WIDTH-1:0]            si [STAGES];
  logic [STAGES-1:0]           ci, zi;
  logic [STAGES-1:0][SW-1:0]   ss;
  pg_t  [STAGES-1:0][NG-1:0]   pg;
  logic [STAGES-1:0][NG:0]     cg;
  logic [WIDTH-1:0]            a_d [NI];
  logic [WIDTH-1:0]            a_q [NI];
  logic [WIDTH-1:0]            b_d [NI];
  logic [WIDTH-1:0]            b_q [NI];
  logic [WIDTH-1:0]            s_d [NI];
  logic [WIDTH-1:0]            s_q [NI];
  logic [NI-1:0]               c_d, c_q, z_d, z_q;
  logic [WIDTH-1:0]            sum_d, sum_q;
  logic                        c_out_d, c_out_q, ovf_d, ovf_q, zero_d, zero_q;

  assign adv       = out_ready | ~v_q[STAGES-1];
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Skew registers hold only the not-yet-added operand bits, shifted down so slice k sits at bit 0
  always_comb begin
    ai[0] = a;
    bi[0] = sub ? ~b : b;
    ci[0] = sub | c_in;
    zi[0] = 1'b1;
    si[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ai[k] = a_q[k-1];
      bi[k] = b_q[k-1];
      ci[k] = c_q[k-1];
      zi[k] = z_q[k-1];
      si[k] = s_q[k-1];
    end
  end

  // Group carries as sum-of-products over group p/g, independent of other groups' carries
  always_comb begin
    logic acc, pr;
    acc = 1'b0;
    pr  = 1'b1;
    cg  = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = 0; j <= NG; j++) begin
        acc = 1'b0;
        pr  = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          acc = acc | (pr & pg[k][i].g);
          pr  = pr & pg[k][i].p;
        end
        cg[k][j] = acc | (pr & ci[k]);
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group u_grp (
        .a    (ai[k][CLA_GROUP_W*j +: CLA_GROUP_W]),
        .b    (bi[k][CLA_GROUP_W*j +: CLA_GROUP_W]),
        .c_in (cg[k][j]),
        .sum  (ss[k][CLA_GROUP_W*j +: CLA_GROUP_W]),
        .pg   (pg[k][j])
      );
    end
  end

  // Finished slices enter the sum at the top and shift down, landing in place after the last stage
  always_comb begin
    v_d = (v_q << 1) | STAGES'(in_valid);
    for (int k = 0; k < NI; k++) begin
      a_d[k] = ai[k] >> SW;
      b_d[k] = bi[k] >> SW;
      s_d[k] = (si[k] >> SW) | (WIDTH'(ss[k]) << (WIDTH - SW));
      c_d[k] = cg[k][NG];
      z_d[k] = zi[k] & ~|ss[k];
    end
    sum_d   = (si[STAGES-1] >> SW) | (WIDTH'(ss[STAGES-1]) << (WIDTH - SW));
    c_out_d = cg[STAGES-1][NG];
    ovf_d   = ai[STAGES-1][SW-1] ^ bi[STAGES-1][SW-1] ^ ss[STAGES-1][SW-1] ^ cg[STAGES-1][NG];
    zero_d  = zi[STAGES-1] & ~|ss[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      v_q     <= v_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < NI; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      z_q <= z_d;
    end
  end
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: table vectors plus scoreboard-driven stall, reset and random streams
module tb_pipe_cla_adder;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] s;
    logic co, ov, z;
  } res_t;
  typedef struct {
    logic [W-1:0] a, b;
    logic ci, sb;
    res_t r;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, c_in = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, c_out, ovf, zero;
  logic [W-1:0] sum;
  int checks = 0, errors = 0, pushed = 0, popped = 0, flushed = 0;
  res_t exp_q[$];
  res_t cur_exp, held_r;
  logic held = 1'b0;

  pipe_cla_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] av, bv, input logic civ, sbv);
    res_t r;
    logic [W:0] t;
    logic [W-1:0] bb;
    bb = sbv ? ~bv : bv;
    t = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, (sbv | civ)};
    r.s = t[W-1:0];
    r.co = t[W];
    r.ov = (av[W-1] == bb[W-1]) && (r.s[W-1] != av[W-1]);
    r.z = (r.s == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [W-1:0] av, bv, input logic civ, sbv, input res_t r);
    a = av; b = bv; c_in = civ; sub = sbv; in_valid = 1'b1; cur_exp = r;
  endtask

  task automatic drive_rnd();
    logic [W-1:0] av, bv;
    logic civ, sbv;
    av = rnd_op(); bv = rnd_op(); civ = 1'($urandom); sbv = 1'($urandom);
    drive(av, bv, civ, sbv, model(av, bv, civ, sbv));
  endtask

  task automatic step(output logic acc);
    @(negedge clk);
    acc = rst_n && in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(cur_exp);
      pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency_check(input string name);
    logic acc;
    int lat;
    step(acc);
    chk({name, "_accept"}, acc, 1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    drain(20);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready", in_ready, out_ready || !out_valid);
      if (held) chk("stall_hold", {sum, c_out, ovf, zero}, {held_r.s, held_r.co, held_r.ov, held_r.z});
      held = out_valid && !out_ready;
      held_r.s = sum; held_r.co = c_out; held_r.ov = ovf; held_r.z = zero;
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          res_t e;
          e = exp_q.pop_front();
          popped++;
          chk("result", {sum, c_out, ovf, zero}, {e.s, e.co, e.ov, e.z});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    logic acc;
    int idx, stall_cnt, bad, cyc, n;
    logic need_new;
    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    tbl[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
    tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    tbl[3]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    tbl[4]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{32'h2345_6789, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
    tbl[8]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, '{32'h0000_0007, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0001_0000, 1'b0, 1'b0, 1'b0}};
    tbl[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(tbl[0].a, tbl[0].b, tbl[0].ci, tbl[0].sb, tbl[0].r);
    latency_check("first");

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, tbl[i].r);
      step(acc);
      chk("tbl_accept", acc, 1);
    end
    drain(20);

    idx = 0; stall_cnt = 0; need_new = 1'b1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (need_new) drive_rnd();
      #1;
      if (!in_ready) stall_cnt++;
      step(acc);
      need_new = acc;
      if (acc) idx++;
    end
    chk("stall_beats", idx, 8);
    chk("stall_cycles", stall_cnt, 2);
    drain(20);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rnd();
      step(acc);
      chk("rst_seq_accept", acc, 1);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    flushed += exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("no_stale_beats", bad, 0);
    drive_rnd();
    latency_check("post_rst");

    idx = 0; cyc = 0; need_new = 1'b1; in_valid = 1'b0;
    while (idx < 10000 && cyc < 60000) begin
      if (need_new || !in_valid) begin
        if (($urandom % 4) != 0) drive_rnd();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom % 4) != 0;
      step(acc);
      need_new = acc;
      if (acc) idx++;
      cyc++;
    end
    chk("random_beats", idx, 10000);
    drain(200);
    chk("beat_count", popped, pushed - flushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
